redun_vdf_ctrl: RTL
===================

// Module: redun_vdf_ctrl
// PURPOSE
//  Iteration controller directly upstream of redun_wrapper; closes the VDF squaring loop.
//  - Accepts a start value x and iteration count T.
//  - Waits for the squarer clock to lock, then issues one square per iteration.
//  - Feeds each result back as the next input; returns y = x^(2^T) in redundant form.
//  - Watchdog flags a lost squarer result, a lock drop, or a spurious valid.
// PARAMETERS
//  ITER_BITS    32     width of iteration count and counter
//  TIMEOUT_CYC  4096   max i_clk cycles from o_sq_start to i_sq_valid before error
// PORTS
//  i_clk        in   1             system clock (same domain as redun_wrapper i_clk)
//  i_reset      in   1             asynchronous, active-high reset
//  i_start      in   1             1-cycle request; sampled only in IDLE or ERR
//  i_x          in   redun0_t      initial value, latched on accepted i_start
//  i_t          in   ITER_BITS     iteration count T, latched on accepted i_start
//  o_busy       out  1             high from accepted start until DONE/ERR
//  o_done       out  1             1-cycle pulse when o_y is final
//  o_y          out  redun0_t      current/final value; holds after DONE
//  o_iter       out  ITER_BITS     completed squarings
//  o_err        out  1             sticky error; cleared by next accepted i_start
//  o_err_code   out  2             0 none, 1 timeout, 2 lock lost, 3 spurious valid
//  o_sq_start   out  1             to redun_wrapper i_start; 1-cycle pulse
//  o_sq_in      out  redun0_t      to redun_wrapper i_sq_in; valid with o_sq_start
//  i_sq_out     in   redun0_t      from redun_wrapper o_sq_out
//  i_sq_valid   in   1             from redun_wrapper o_valid
//  i_locked     in   1             from redun_wrapper o_locked
// BEHAVIOUR
//  Reset (async assert): state=IDLE, all outputs 0, o_y=0, o_err_code=0, counters 0.
//  States: IDLE, WAIT_LOCK, ISSUE, WAIT_RES, DONE, ERR.
//  IDLE/ERR + i_start:
//   - latch x into o_y and T into t_reg; o_iter=0; clear err; o_busy=1.
//   - T==0 -> DONE next cycle; no square issued.
//   - else -> WAIT_LOCK.
//  WAIT_LOCK: stay until i_locked=1, then ISSUE; no timeout here.
//  ISSUE (1 cycle):
//   - o_sq_start=1, o_sq_in=o_y (registered outputs); clear watchdog; -> WAIT_RES.
//  WAIT_RES:
//   - on i_sq_valid: o_y<=i_sq_out, o_iter++.
//   - o_iter+1==t_reg -> DONE, else -> ISSUE.
//   - Min turnaround: valid in cycle n gives o_sq_start in cycle n+1.
//  DONE (1 cycle): o_done=1, o_busy=0 -> IDLE. o_y/o_iter hold until next start.
//  ERR:
//   - entered from WAIT_RES on timeout (watchdog reaches TIMEOUT_CYC with no valid).
//   - entered from WAIT_RES/ISSUE when i_locked falls (code 2).
//   - entered from any state except WAIT_RES when i_sq_valid arrives while busy (code 3).
//   - o_err=1, o_busy=0; hold until i_start.
//  Error priority if simultaneous: lock lost > timeout > spurious.
//  i_sq_valid in IDLE/DONE/ERR: ignored, no error.
//  i_start while busy: ignored (no restart, no error).
//  i_sq_valid coinciding with timeout terminal count: valid wins (result accepted).
//  T=2^ITER_BITS-1: counter compares equality, never wraps past t_reg.
//  Async reset mid-operation:
//   - immediate return to IDLE; o_sq_start deasserts.
//   - any late i_sq_valid after reset is ignored.
// STRUCTURE
//  redun_mont_pkg: reuse redun0_t, NUM_WRDS, WRD_BITS.
//   - add typedef enum vdf_ctrl_state_t.
//   - add typedef enum vdf_err_t {ERR_NONE, ERR_TIMEOUT, ERR_LOCK, ERR_SPUR}.
//  Sub-module: redun_wdog (clearable up-counter, terminal-count flag, param TIMEOUT_CYC).
//  Everything else inline; single always_ff with async reset for FSM and datapath regs.
// TESTING
//  Bench uses a behavioural squarer model with fixed latency L=20; compare against a
//  reference model working in the canonical (non-redundant) integer domain.
//  1. x=3, T=1, locked=1 -> one o_sq_start with o_sq_in=3; o_done; canonical o_y=9; o_iter=1.
//  2. x=2, T=5 -> five o_sq_start pulses, each 1 cycle after the previous valid;
//     canonical o_y=2^32 mod N; o_iter=5.
//  3. T=0, x=7 -> o_done 1 cycle after start, o_sq_start never asserted, o_y=7.
//  4. locked=0 for 100 cycles after start -> no o_sq_start until locked rises; then normal.
//  5. Squarer drops result, TIMEOUT_CYC=64 -> o_err=1, code 1, exactly 64 cycles after
//     o_sq_start; new i_start clears the error.
//  6. Lock falls mid-run (iter 3 of 10) -> code 2.
//     Async reset during WAIT_RES -> IDLE, outputs 0, late valid ignored.

Source files
------------

// File: rtl/redun_vdf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : redun_vdf_ctrl_pkg
//  Description : Shared types for the VDF iteration controller: redundant
//                operand layout, controller state and error-code encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package redun_vdf_ctrl_pkg;

  // Redundant operand: NUM_WRDS limbs of WRD_BITS payload plus one carry bit.
  // Canonical value = sum(limb[i] << (i*WRD_BITS)).
  localparam int NUM_WRDS = 4;
  localparam int WRD_BITS = 16;

  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_RES  = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } vdf_ctrl_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_LOCK    = 2'd2,
    ERR_SPUR    = 2'd3
  } vdf_err_t;

endpackage
`default_nettype wire

// File: rtl/redun_vdf_ctrl_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : redun_wdog
//  Description : Clearable up-counter measuring cycles since a squarer start
//                pulse; flags the last cycle a result may still arrive.
//  Revision    : 1.0  initial release
// ============================================================================
module redun_wdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int                 c_cnt_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_tc    = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // The clear cycle is the start-pulse cycle itself, so it loads 1; the count
  // then equals cycles elapsed since the pulse and saturates at terminal.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= c_cnt_w'(1);
    end else if (i_en && (r_cnt != c_tc)) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Terminal flag: final permitted cycle, so an error registers exactly
  // TIMEOUT_CYC cycles after the start pulse.
  assign o_tc = i_en && (r_cnt == c_tc);

endmodule
`default_nettype wire

// File: rtl/redun_vdf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : redun_vdf_ctrl
//  Description : VDF iteration controller. Waits for squarer lock, issues one
//                square per iteration, feeds results back, returns x^(2^T),
//                and watches for lost results, lock drops and spurious valids.
//  Revision    : 1.0  initial release
// ============================================================================
module redun_vdf_ctrl
  import redun_vdf_ctrl_pkg::*;
#(
  parameter int ITER_BITS   = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  redun0_t              i_x,
  input  logic [ITER_BITS-1:0] i_t,
  output logic                 o_busy,
  output logic                 o_done,
  output redun0_t              o_y,
  output logic [ITER_BITS-1:0] o_iter,
  output logic                 o_err,
  output logic [1:0]           o_err_code,
  output logic                 o_sq_start,
  output redun0_t              o_sq_in,
  input  redun0_t              i_sq_out,
  input  logic                 i_sq_valid,
  input  logic                 i_locked
);

  vdf_ctrl_state_t      r_state;
  vdf_err_t             r_err_code;
  logic [ITER_BITS-1:0] r_t;

  vdf_err_t             w_err;
  logic                 w_wd_tc;
  logic [ITER_BITS-1:0] w_iter_nxt;

  assign w_iter_nxt = o_iter + ITER_BITS'(1);
  assign o_err_code = r_err_code;

  redun_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (r_state == ST_ISSUE),
    .i_en    (r_state == ST_WAIT_RES),
    .o_tc    (w_wd_tc)
  );

  // Error detection in priority order: lock lost, timeout, spurious valid.
  // A valid arriving on the terminal count is a real result, not a timeout.
  always_comb begin
    w_err = ERR_NONE;
    if (((r_state == ST_ISSUE) || (r_state == ST_WAIT_RES)) && !i_locked) begin
      w_err = ERR_LOCK;
    end else if ((r_state == ST_WAIT_RES) && !i_sq_valid && w_wd_tc) begin
      w_err = ERR_TIMEOUT;
    end else if (((r_state == ST_WAIT_LOCK) || (r_state == ST_ISSUE)) && i_sq_valid) begin
      w_err = ERR_SPUR;
    end
  end

  // Controller FSM and datapath registers; pulses default low each cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_err_code <= ERR_NONE;
      r_t        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_y        <= '0;
      o_iter     <= '0;
      o_err      <= 1'b0;
      o_sq_start <= 1'b0;
      o_sq_in    <= '0;
    end else begin
      o_done     <= 1'b0;
      o_sq_start <= 1'b0;
      if (w_err != ERR_NONE) begin
        r_state    <= ST_ERR;
        r_err_code <= w_err;
        o_err      <= 1'b1;
        o_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_ERR: begin
            if (i_start) begin
              o_y        <= i_x;
              r_t        <= i_t;
              o_iter     <= '0;
              o_err      <= 1'b0;
              r_err_code <= ERR_NONE;
              if (i_t == '0) begin
                r_state <= ST_DONE;
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
              end else begin
                r_state <= ST_WAIT_LOCK;
                o_busy  <= 1'b1;
              end
            end
          end
          ST_WAIT_LOCK: begin
            if (i_locked) begin
              r_state    <= ST_ISSUE;
              o_sq_start <= 1'b1;
              o_sq_in    <= o_y;
            end
          end
          ST_ISSUE: begin
            r_state <= ST_WAIT_RES;
          end
          ST_WAIT_RES: begin
            if (i_sq_valid) begin
              o_y    <= i_sq_out;
              o_iter <= w_iter_nxt;
              if (w_iter_nxt == r_t) begin
                r_state <= ST_DONE;
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
              end else begin
                // Result goes straight back out for the next squaring.
                r_state    <= ST_ISSUE;
                o_sq_start <= 1'b1;
                o_sq_in    <= i_sq_out;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
